// File: rtl/bram_bridge_pkg.sv
// bram_bridge_pkg: shared definitions for the CPU-to-BRAM bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, open-bus read value, supported channel limit.
package bram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_HOLD = 2'd3
  } state_e;

  // Byte returned to the CPU when a read hits no BRAM window.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // Largest number of BRAM channels the bridge decodes.
  localparam int unsigned MAX_CH = 4;

endpackage

// File: rtl/bram_bridge_decode.sv
// bram_bridge_decode: maps a CPU address onto one BRAM channel window.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_i (CPU address) -> sel_o (one-hot channel), hit_o (any window
//        matched), offset_o (address masked to the selected window).
module bram_bridge_decode
  import bram_bridge_pkg::*;
#(
  parameter int unsigned            P_NUM_CH = 2,
  parameter logic [16*P_NUM_CH-1:0] P_BASE   = {16'hC000, 16'h8000},
  parameter logic [16*P_NUM_CH-1:0] P_MASK   = {16'h1FFF, 16'h1FFF}
) (
  input  logic [15:0]         addr_i,
  output logic [P_NUM_CH-1:0] sel_o,
  output logic                hit_o,
  output logic [15:0]         offset_o
);

  localparam int unsigned NCH = (P_NUM_CH > MAX_CH) ? MAX_CH : P_NUM_CH;

  // Windows may overlap; the lowest matching channel index wins, so the
  // scan runs upward and stops claiming once a hit has been recorded.
  always_comb begin
    sel_o    = '0;
    hit_o    = 1'b0;
    offset_o = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (!hit_o && ((addr_i & ~P_MASK[16*i +: 16]) == P_BASE[16*i +: 16])) begin
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
        offset_o = addr_i & P_MASK[16*i +: 16];
      end
    end
  end

endmodule

// File: rtl/bram_bridge.sv
// bram_bridge: asynchronous-strobe CPU bus to multi-channel BRAM bridge.
// Latency: write completes 1 cycle after strobe edge detect; read O_RDY
//          P_RD_LAT+1 cycles after edge detect. Backpressure: none; the CPU
//          holds its strobe until O_RDY and a new access needs a new edge.
// Ports: I_CLK/I_RESET (sync, active high); CPU side I_ADDR, IO_DATA,
//        I_WE_L, I_RE_L, O_RDY; BRAM side O_BRAM_EN/WE (per channel),
//        O_BRAM_ADDR, O_BRAM_DIN (shared), I_BRAM_DOUT (per channel byte).
// Option: define BRAM_BRIDGE_ERR_EN to build the sticky O_ERR flag that
//         records any access to an unmapped address.
module bram_bridge
  import bram_bridge_pkg::*;
#(
  parameter int unsigned            P_NUM_CH = 2,
  parameter int unsigned            P_RD_LAT = 1,
  parameter logic [16*P_NUM_CH-1:0] P_BASE   = {16'hC000, 16'h8000},
  parameter logic [16*P_NUM_CH-1:0] P_MASK   = {16'h1FFF, 16'h1FFF}
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic [15:0]           I_ADDR,
  inout  wire  [7:0]            IO_DATA,
  input  logic                  I_WE_L,
  input  logic                  I_RE_L,
  output logic                  O_RDY,
  output logic [P_NUM_CH-1:0]   O_BRAM_EN,
  output logic [P_NUM_CH-1:0]   O_BRAM_WE,
  output logic [15:0]           O_BRAM_ADDR,
  output logic [7:0]            O_BRAM_DIN,
  input  logic [8*P_NUM_CH-1:0] I_BRAM_DOUT,
  output logic                  O_ERR
);

  localparam logic [1:0] RD_LAT_C = (P_RD_LAT >= 2) ? 2'd2 : 2'd1;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                re_l_q, we_l_q;
  logic [P_NUM_CH-1:0] sel_q, sel_d;
  logic                hit_q, hit_d;
  logic [P_NUM_CH-1:0] en_q, en_d;
  logic [P_NUM_CH-1:0] bwe_q, bwe_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          din_q, din_d;
  logic [7:0]          rd_q, rd_d;

  logic [P_NUM_CH-1:0] dec_sel;
  logic                dec_hit;
  logic [15:0]         dec_off;
  logic                we_fall, re_fall, start, capture;
  logic [7:0]          bram_byte;
  logic                rdy, drive;

  bram_bridge_decode #(
    .P_NUM_CH (P_NUM_CH),
    .P_BASE   (P_BASE),
    .P_MASK   (P_MASK)
  ) u_decode (
    .addr_i   (I_ADDR),
    .sel_o    (dec_sel),
    .hit_o    (dec_hit),
    .offset_o (dec_off)
  );

  // Falling edge = registered strobe still high, live strobe now low.
  assign we_fall = we_l_q & ~I_WE_L;
  assign re_fall = re_l_q & ~I_RE_L;
  assign start   = (state_q == ST_IDLE) && (we_fall || re_fall);

  // State register.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A write edge outranks a read edge in the same cycle.
  // Releasing the read strobe while waiting on the BRAM abandons the read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (we_fall) begin
          state_d = ST_WRITE;
        end else if (re_fall) begin
          state_d = ST_RD_WAIT;
          cnt_d   = RD_LAT_C;
        end
      end
      ST_WRITE:   state_d = ST_IDLE;
      ST_RD_WAIT: begin
        if (I_RE_L) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 2'd1) begin
          state_d = ST_RD_HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RD_HOLD: begin
        if (I_RE_L) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic. Ready and bus drive drop in the same cycle the CPU lets
  // go of the read strobe, so they follow I_RE_L combinationally.
  always_comb begin
    rdy   = 1'b0;
    drive = 1'b0;
    case (state_q)
      ST_WRITE:   rdy = 1'b1;
      ST_RD_HOLD: begin
        rdy   = ~I_RE_L;
        drive = ~I_RE_L;
      end
      default:    ;
    endcase
  end

  // Byte from the channel latched at request time; open bus if unmapped.
  always_comb begin
    bram_byte = OPEN_BUS;
    if (hit_q) begin
      for (int i = 0; i < int'(P_NUM_CH); i++) begin
        if (sel_q[i]) bram_byte = I_BRAM_DOUT[8*i +: 8];
      end
    end
  end

  assign capture = (state_q == ST_RD_WAIT) && (state_d == ST_RD_HOLD);

  // Datapath next state. Address, select and write data are frozen at the
  // edge-detect cycle so later CPU bus activity cannot disturb the access.
  always_comb begin
    en_d   = '0;
    bwe_d  = '0;
    sel_d  = sel_q;
    hit_d  = hit_q;
    addr_d = addr_q;
    din_d  = din_q;
    rd_d   = rd_q;
    if (start) begin
      sel_d  = dec_sel;
      hit_d  = dec_hit;
      addr_d = dec_off;
      en_d   = dec_sel;
      if (we_fall) begin
        bwe_d = dec_sel;
        din_d = IO_DATA;
      end
    end
    if (capture) rd_d = bram_byte;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      re_l_q <= 1'b1;
      we_l_q <= 1'b1;
      sel_q  <= '0;
      hit_q  <= 1'b0;
      en_q   <= '0;
      bwe_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      rd_q   <= '0;
    end else begin
      re_l_q <= I_RE_L;
      we_l_q <= I_WE_L;
      sel_q  <= sel_d;
      hit_q  <= hit_d;
      en_q   <= en_d;
      bwe_q  <= bwe_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      rd_q   <= rd_d;
    end
  end

`ifdef BRAM_BRIDGE_ERR_EN
  logic err_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      err_q <= 1'b0;
    end else if (start && !dec_hit) begin
      err_q <= 1'b1;
    end
  end

  assign O_ERR = err_q;
`else
  assign O_ERR = 1'b0;
`endif

  assign IO_DATA     = drive ? rd_q : 8'bz;
  assign O_RDY       = rdy;
  assign O_BRAM_EN   = en_q;
  assign O_BRAM_WE   = bwe_q;
  assign O_BRAM_ADDR = addr_q;
  assign O_BRAM_DIN  = din_q;

endmodule

// File: tb/tb_bram_bridge.sv
// tb_bram_bridge: two bridges side by side on one CPU bus; instance 0 uses
// the default windows with 1-cycle BRAM latency, instance 1 uses two
// overlapping windows at 16'h8000 with 2-cycle latency.
module tb_bram_bridge;

  localparam logic [31:0] BASE_A = {16'hC000, 16'h8000};
  localparam logic [31:0] BASE_B = {16'h8000, 16'h8000};
  localparam logic [31:0] MASK_C = {16'h1FFF, 16'h1FFF};
  localparam int NEVER  = 32'h7FFF_FFFF;
  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_BOTH = 2;
  localparam int K_ABT  = 3;
  localparam int K_RST  = 4;

  typedef struct {
    int          dut;
    int          cyc;
    logic [1:0]  en;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        wr;
  } acc_t;

  typedef struct {
    int         dut;
    int         cyc;
    logic       rd;
    logic [7:0] dat;
  } rdy_t;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        we_l, re_l, cpu_oe;
  logic [7:0]  cpu_dat;
  logic [15:0] dout0, dout1;
  tri0  [7:0]  io0, io1;
  logic        rdy0, rdy1, err0, err1;
  logic [1:0]  en0, en1, bwe0, bwe1;
  logic [15:0] ba0, ba1;
  logic [7:0]  bd0, bd1;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   err_at [2];
  logic holding [2];
  logic wpulse [2];
  logic [7:0] hold_dat [2];
  logic mon_on;
  acc_t q_acc [$];
  rdy_t q_rdy [$];

  assign io0 = cpu_oe ? cpu_dat : 8'bz;
  assign io1 = cpu_oe ? cpu_dat : 8'bz;

  bram_bridge #(.P_NUM_CH(2), .P_RD_LAT(1), .P_BASE(BASE_A), .P_MASK(MASK_C)) u_dut0 (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(addr), .IO_DATA(io0), .I_WE_L(we_l),
    .I_RE_L(re_l), .O_RDY(rdy0), .O_BRAM_EN(en0), .O_BRAM_WE(bwe0),
    .O_BRAM_ADDR(ba0), .O_BRAM_DIN(bd0), .I_BRAM_DOUT(dout0), .O_ERR(err0));

  bram_bridge #(.P_NUM_CH(2), .P_RD_LAT(2), .P_BASE(BASE_B), .P_MASK(MASK_C)) u_dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(addr), .IO_DATA(io1), .I_WE_L(we_l),
    .I_RE_L(re_l), .O_RDY(rdy1), .O_BRAM_EN(en1), .O_BRAM_WE(bwe1),
    .O_BRAM_ADDR(ba1), .O_BRAM_DIN(bd1), .I_BRAM_DOUT(dout1), .O_ERR(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Window rules: lowest channel whose base matches the unmasked bits.
  function automatic void dec(input int k, input logic [15:0] a, output logic hit,
                              output logic [1:0] sel, output logic [15:0] off);
    logic [31:0] b, m;
    b = (k == 0) ? BASE_A : BASE_B;
    m = MASK_C;
    hit = 1'b0; sel = 2'b00; off = 16'h0;
    for (int i = 0; i < 2; i++) begin
      if (!hit && ((a & ~m[16*i +: 16]) == b[16*i +: 16])) begin
        hit = 1'b1; sel[i] = 1'b1; off = a & m[16*i +: 16];
      end
    end
  endfunction

  task automatic mon(input int k, input logic rdy, input logic [1:0] en, input logic [1:0] we,
                     input logic [15:0] ba, input logic [7:0] bd, input logic [7:0] io,
                     input logic err);
    int idx;
    acc_t a;
    rdy_t r;
    logic exp_err;
    if (en != 2'b00 || we != 2'b00) begin
      idx = -1;
      foreach (q_acc[i]) if (idx < 0 && q_acc[i].dut == k) idx = i;
      if (idx < 0) chk($sformatf("d%0d bram strobe unexpected", k), {28'h0, en, we}, 32'h0);
      else begin
        a = q_acc[idx];
        q_acc.delete(idx);
        chk($sformatf("d%0d bram cycle", k), cyc, a.cyc);
        chk($sformatf("d%0d bram en", k), {30'h0, en}, {30'h0, a.en});
        chk($sformatf("d%0d bram we", k), {30'h0, we}, {30'h0, a.we});
        chk($sformatf("d%0d bram addr", k), {16'h0, ba}, {16'h0, a.addr});
        if (a.wr) chk($sformatf("d%0d bram din", k), {24'h0, bd}, {24'h0, a.din});
      end
    end
    if (holding[k]) begin
      if (!re_l) begin
        chk($sformatf("d%0d rdy held", k), {31'h0, rdy}, 32'h1);
        chk($sformatf("d%0d read data held", k), {24'h0, io}, {24'h0, hold_dat[k]});
      end else begin
        chk($sformatf("d%0d rdy release", k), {31'h0, rdy}, 32'h0);
        chk($sformatf("d%0d bus release", k), {24'h0, io}, 32'h0);
        holding[k] = 1'b0;
      end
    end else if (wpulse[k]) begin
      chk($sformatf("d%0d write rdy width", k), {31'h0, rdy}, 32'h0);
      wpulse[k] = 1'b0;
    end else if (rdy) begin
      idx = -1;
      foreach (q_rdy[i]) if (idx < 0 && q_rdy[i].dut == k) idx = i;
      if (idx < 0) chk($sformatf("d%0d rdy unexpected", k), {31'h0, rdy}, 32'h0);
      else begin
        r = q_rdy[idx];
        q_rdy.delete(idx);
        chk($sformatf("d%0d rdy cycle", k), cyc, r.cyc);
        if (r.rd) begin
          chk($sformatf("d%0d read data", k), {24'h0, io}, {24'h0, r.dat});
          holding[k] = 1'b1;
          hold_dat[k] = r.dat;
        end else wpulse[k] = 1'b1;
      end
    end else if (!cpu_oe) begin
      chk($sformatf("d%0d bus idle", k), {24'h0, io}, 32'h0);
    end
`ifdef BRAM_BRIDGE_ERR_EN
    exp_err = (cyc >= err_at[k]);
`else
    exp_err = 1'b0;
`endif
    chk($sformatf("d%0d err", k), {31'h0, err}, {31'h0, exp_err});
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, rdy0, en0, bwe0, ba0, bd0, io0, err0);
      mon(1, rdy1, en1, bwe1, ba1, bd1, io1, err1);
    end
  end

  task automatic reset_chk();
    chk("d0 reset strobes", {28'h0, en0, bwe0}, 32'h0);
    chk("d1 reset strobes", {28'h0, en1, bwe1}, 32'h0);
    chk("d0 reset addr/din", {8'h0, ba0, bd0}, 32'h0);
    chk("d1 reset addr/din", {8'h0, ba1, bd1}, 32'h0);
    chk("d0 reset rdy/err", {30'h0, rdy0, err0}, 32'h0);
    chk("d1 reset rdy/err", {30'h0, rdy1, err1}, 32'h0);
    chk("d0 reset bus", {24'h0, io0}, 32'h0);
    chk("d1 reset bus", {24'h0, io1}, 32'h0);
  endtask

  // Issue one CPU access and push what each bridge must do in response.
  task automatic txn(input int kind, input logic [15:0] a, input logic [7:0] d);
    int n, h;
    logic hit;
    logic [1:0] sel;
    logic [15:0] off, dv;
    logic [7:0] byt;
    @(posedge clk); #1;
    n = cyc;
    addr = a;
    for (int k = 0; k < 2; k++) begin
      dec(k, a, hit, sel, off);
      dv = (k == 0) ? dout0 : dout1;
      byt = 8'hFF;
      for (int i = 0; i < 2; i++) if (sel[i]) byt = dv[8*i +: 8];
      if (!hit && err_at[k] == NEVER) err_at[k] = n + 1;
      if (kind == K_WR || kind == K_BOTH) begin
        if (hit) q_acc.push_back('{k, n + 1, sel, sel, off, d, 1'b1});
        q_rdy.push_back('{k, n + 1, 1'b0, 8'h00});
      end else begin
        if (hit) q_acc.push_back('{k, n + 1, sel, 2'b00, off, 8'h00, 1'b0});
        if (kind == K_RD) q_rdy.push_back('{k, n + k + 2, 1'b1, byt});
      end
    end
    if (kind == K_WR || kind == K_BOTH) begin
      cpu_dat = d;
      cpu_oe  = 1'b1;
      we_l    = 1'b0;
    end
    if (kind != K_WR) re_l = 1'b0;
    case (kind)
      K_WR, K_BOTH: begin
        @(posedge clk); #1;
        we_l = 1'b1; re_l = 1'b1; cpu_oe = 1'b0;
      end
      K_RD: begin
        h = $urandom_range(0, 3);
        repeat (4 + h) @(posedge clk);
        #1 re_l = 1'b1;
      end
      K_ABT: begin
        @(posedge clk); #1;
        re_l = 1'b1;
      end
      default: begin
        @(posedge clk); #1;
        rst = 1'b1; re_l = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        err_at[0] = NEVER;
        err_at[1] = NEVER;
        @(negedge clk);
        reset_chk();
      end
    endcase
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [15:0] a;
    int kind, reg_sel;
    rst = 1'b1; we_l = 1'b1; re_l = 1'b1; cpu_oe = 1'b0; cpu_dat = 8'h00;
    addr = 16'h0; dout0 = 16'h0; dout1 = 16'h0; mon_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      err_at[k] = NEVER; holding[k] = 1'b0; wpulse[k] = 1'b0; hold_dat[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_chk();
    mon_on = 1'b1;

    txn(K_WR, 16'hC123, 8'h5A);
    dout0 = 16'h773C; dout1 = 16'h663C;
    txn(K_RD, 16'h8010, 8'h00);
    txn(K_RD, 16'h4000, 8'h00);
    txn(K_BOTH, 16'h8000, 8'hA5);
    txn(K_RD, 16'h8000, 8'h00);
    txn(K_RST, 16'h8010, 8'h00);
    txn(K_ABT, 16'h9000, 8'h00);
    txn(K_WR, 16'h9FFF, 8'hC3);

    for (int t = 0; t < 160; t++) begin
      reg_sel = $urandom_range(0, 3);
      a = 16'($urandom);
      case (reg_sel)
        0: a = {3'b100, a[12:0]};
        1: a = {3'b110, a[12:0]};
        2: a = {($urandom_range(0, 1) == 0) ? 3'b101 : 3'b111, a[12:0]};
        default: ;
      endcase
      dout0 = 16'($urandom);
      dout1 = 16'($urandom);
      kind = $urandom_range(0, 19);
      if (kind < 8) kind = K_WR;
      else if (kind < 16) kind = K_RD;
      else if (kind < 18) kind = K_BOTH;
      else if (kind < 19) kind = K_ABT;
      else kind = K_RST;
      txn(kind, a, 8'($urandom));
    end

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bram events outstanding", q_acc.size(), 32'h0);
    chk("rdy events outstanding", q_rdy.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_bridge.md
BRAM_BRIDGE -- requirements
Module: bram_bridge

Interface
REQ-001 SHALL have parameter P_NUM_CH, default 2: number of BRAM channels, 1..4.
REQ-002 SHALL have parameter P_RD_LAT, default 1: BRAM read latency in clocks, 1 or 2.
REQ-003 SHALL have parameter P_BASE, default {16'hC000,16'h8000}: packed 16-bit base address per channel, channel 0 in the LSBs.
REQ-004 SHALL have parameter P_MASK, default {16'h1FFF,16'h1FFF}: packed 16-bit offset mask per channel; window = P_BASE..P_BASE|P_MASK.
REQ-005 Ports; one clock; reset is synchronous and active-high:
  I_CLK  in  1  clock.
  I_RESET  in  1  synchronous active-high reset.
  I_ADDR  in  16  CPU address.
  IO_DATA  inout  8  CPU data bus, tristated unless driving read data.
  I_WE_L  in  1  CPU write strobe, active low.
  I_RE_L  in  1  CPU read strobe, active low.
  O_RDY  out  1  access complete.
  O_BRAM_EN  out  P_NUM_CH  per-channel BRAM enable.
  O_BRAM_WE  out  P_NUM_CH  per-channel BRAM write enable.
  O_BRAM_ADDR  out  16  shared BRAM address = I_ADDR & P_MASK[sel], registered.
  O_BRAM_DIN  out  8  shared BRAM write data, registered.
  I_BRAM_DOUT  in  8*P_NUM_CH  per-channel BRAM read data, channel 0 in LSBs.
  O_ERR  out  1  sticky unmapped-access flag (only with BRAM_BRIDGE_ERR_EN; tied 0 otherwise).

Function
REQ-006 SHALL register I_RE_L/I_WE_L and start an access only on a strobe falling edge (registered high, current low) while in IDLE.
REQ-007 Channel select SHALL be the lowest index i with (I_ADDR & ~P_MASK[i]) == P_BASE[i]; no match = unmapped.
REQ-008 FSM states: IDLE, WRITE, RD_WAIT, RD_HOLD.
REQ-009 IDLE->WRITE on WE edge: O_BRAM_EN[sel], O_BRAM_WE[sel] high for exactly one cycle, O_BRAM_DIN = IO_DATA sampled at edge, O_RDY high that cycle; WRITE->IDLE unconditionally.
REQ-010 IDLE->RD_WAIT on RE edge: O_BRAM_EN[sel] high one cycle, O_BRAM_WE low; counter loaded with P_RD_LAT.
REQ-011 RD_WAIT SHALL capture I_BRAM_DOUT[sel] when the counter expires (P_RD_LAT cycles after EN) and go to RD_HOLD.
REQ-012 RD_HOLD SHALL drive captured byte on IO_DATA and hold O_RDY high while I_RE_L low; on I_RE_L high, tristate IO_DATA and deassert O_RDY the same cycle, next state IDLE.
REQ-013 Read-request-to-O_RDY latency SHALL be P_RD_LAT+1 cycles after the edge-detect cycle.
REQ-014 Simultaneous RE and WE edges: write SHALL win, read ignored.
REQ-015 Unmapped write: no O_BRAM_EN/WE, O_RDY still pulses. Unmapped read: captured byte 8'hFF, normal timing.
REQ-016 I_ADDR/strobe changes during RD_WAIT SHALL be ignored; I_RE_L rising in RD_WAIT SHALL abort to IDLE without driving IO_DATA.
REQ-017 IO_DATA SHALL never be driven outside RD_HOLD.

Reset
REQ-018 On I_CLK edge with I_RESET high: state IDLE, O_RDY 0, O_BRAM_EN 0, O_BRAM_WE 0, O_BRAM_ADDR 0, O_BRAM_DIN 0, capture reg 0, O_ERR 0, strobe registers 1, IO_DATA tristated; mid-access reset discards the access.

Configuration
REQ-019 With BRAM_BRIDGE_ERR_EN defined, O_ERR SHALL set on any unmapped access and stay set until reset; without it, O_ERR constant 0 and no flag register exists.

Structure
REQ-020 Package bram_bridge_pkg SHALL hold the FSM state encoding, the 8'hFF open-bus constant and the channel-count limit.
REQ-021 Address decode SHALL be sub-module bram_bridge_decode (I_ADDR -> one-hot select + hit), combinational.

Verification
REQ-022 Write 8'h5A to 16'hC123 (defaults) -> O_BRAM_EN=2'b10, O_BRAM_WE=2'b10 one cycle, O_BRAM_ADDR=16'h0123, O_BRAM_DIN=8'h5A, O_RDY one cycle.
REQ-023 Read 16'h8010 with DOUT ch0=8'h3C, P_RD_LAT=1 then 2 -> IO_DATA=8'h3C, O_RDY at 2 and 3 cycles after edge detect, held until I_RE_L high.
REQ-024 Read 16'h4000 (unmapped) -> no BRAM_EN, IO_DATA=8'hFF; with BRAM_BRIDGE_ERR_EN, O_ERR=1 until reset.
REQ-025 RE and WE fall same cycle at 16'h8000 -> single write, no read, IO_DATA stays Z.
REQ-026 Overlapping windows (both base 16'h8000) -> only channel 0 enabled.
REQ-027 I_RESET asserted in RD_WAIT -> next cycle IDLE, all outputs reset values, IO_DATA Z, no O_RDY.
